// File: rtl/kernel_multiplier.sv
// kernel_multiplier: stores a KxK kernel and an NxN image loaded serially,
// then emits one vector of K*K unsigned products per pixel in raster order
// over a valid/ready handshake toward the transposed-conv decoder.

// One product lane: registers pixel * weight at full double width.
module kernel_multiplier_lane #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   pixel,
    input  logic [W-1:0]   weight,
    output logic [2*W-1:0] product
);
    // Product register; cleared by reset, updated only in the MULT cycle
    always_ff @(posedge clk) begin
        if (rst)     product <= '0;
        else if (en) product <= {{W{1'b0}}, pixel} * {{W{1'b0}}, weight};
    end
endmodule

module kernel_multiplier #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       load_kernel,
    input  logic                                       load_input,
    input  logic [PIXEL_WIDTH-1:0]                     data_in,
    input  logic                                       data_valid,
    input  logic                                       start,
    output logic [K*K*2*PIXEL_WIDTH-1:0]               multiplied_image,
    output logic                                       prod_valid,
    input  logic                                       prod_ready,
    output logic [((N*N > 1) ? $clog2(N*N) : 1)-1:0]   pixel_index,
    output logic                                       busy,
    output logic                                       done
);
    localparam int PW2 = 2 * PIXEL_WIDTH;
    localparam int KK  = K * K;
    localparam int NN  = N * N;
    localparam int WW  = (KK > 1) ? $clog2(KK) : 1;
    localparam int IW  = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(KK - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NN - 1);

    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_I, MULT, HOLD, DONE} state_t;

    state_t state, state_nxt;

    logic [PIXEL_WIDTH-1:0] weight_mem [KK];
    logic [PIXEL_WIDTH-1:0] pixel_mem  [NN];
    logic [WW-1:0]          wcnt;
    logic [IW-1:0]          icnt;
    logic [IW-1:0]          pixel_idx;
    logic                   kernel_loaded;
    logic                   input_loaded;
    logic                   mult_en;
    logic [PIXEL_WIDTH-1:0] cur_pixel;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mult_en   = (state == MULT);
    assign cur_pixel = pixel_mem[pixel_idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; kernel load has priority over image load
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_kernel)                                 state_nxt = LOAD_K;
                else if (load_input)                             state_nxt = LOAD_I;
                else if (start && kernel_loaded && input_loaded) state_nxt = MULT;
            end
            LOAD_K: if (data_valid && wcnt == W_LAST) state_nxt = IDLE;
            LOAD_I: if (data_valid && icnt == I_LAST) state_nxt = IDLE;
            MULT:   state_nxt = HOLD;
            HOLD: begin
                if (prod_ready) state_nxt = (pixel_idx == I_LAST) ? DONE : MULT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage writes; deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD_K && data_valid) weight_mem[wcnt] <= data_in;
        if (!rst && state == LOAD_I && data_valid) pixel_mem[icnt]  <= data_in;
    end

    // Counters, loaded flags and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt          <= '0;
            icnt          <= '0;
            pixel_idx     <= '0;
            kernel_loaded <= 1'b0;
            input_loaded  <= 1'b0;
            prod_valid    <= 1'b0;
            pixel_index   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_kernel) begin
                        kernel_loaded <= 1'b0;
                        wcnt          <= '0;
                    end else if (load_input) begin
                        input_loaded <= 1'b0;
                        icnt         <= '0;
                    end else if (start && kernel_loaded && input_loaded) begin
                        pixel_idx <= '0;
                    end
                end
                LOAD_K: begin
                    if (data_valid) begin
                        if (wcnt == W_LAST) begin
                            wcnt          <= '0;
                            kernel_loaded <= 1'b1;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                LOAD_I: begin
                    if (data_valid) begin
                        if (icnt == I_LAST) begin
                            icnt         <= '0;
                            input_loaded <= 1'b1;
                        end else begin
                            icnt <= icnt + IW'(1);
                        end
                    end
                end
                MULT: begin
                    prod_valid  <= 1'b1;
                    pixel_index <= pixel_idx;
                end
                HOLD: begin
                    if (prod_ready) begin
                        prod_valid <= 1'b0;
                        if (pixel_idx != I_LAST) pixel_idx <= pixel_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // One lane per kernel weight, all sharing the current pixel
    for (genvar k = 0; k < KK; k++) begin : g_lane
        kernel_multiplier_lane #(.W(PIXEL_WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (mult_en),
            .pixel   (cur_pixel),
            .weight  (weight_mem[k]),
            .product (multiplied_image[k*PW2 +: PW2])
        );
    end
endmodule

// File: tb/tb_kernel_multiplier.sv
// Directed bench for kernel_multiplier (N=2, K=3, 8-bit).
module tb_kernel_multiplier;
    localparam int N = 2, K = 3, PW = 8, PW2 = 16, KK = 9, NN = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_kernel = 1'b0, load_input = 1'b0;
    logic [PW-1:0]  data_in = '0;
    logic           data_valid = 1'b0, start = 1'b0, prod_ready = 1'b0;
    logic [KK*PW2-1:0] multiplied_image;
    logic           prod_valid, busy, done;
    logic [1:0]     pixel_index;

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] wbuf [KK];
    logic [PW-1:0] pbuf [NN];

    kernel_multiplier #(.N(N), .K(K), .PIXEL_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .load_kernel(load_kernel), .load_input(load_input),
        .data_in(data_in), .data_valid(data_valid), .start(start),
        .multiplied_image(multiplied_image), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .pixel_index(pixel_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected product vector for one pixel against the bench's weight copy
    function automatic logic [KK*PW2-1:0] exp_vec(input logic [PW-1:0] pix);
        logic [KK*PW2-1:0] v;
        v = '0;
        for (int k = 0; k < KK; k++) v[k*PW2 +: PW2] = PW2'(pix) * PW2'(wbuf[k]);
        return v;
    endfunction

    // Serial load stimulus; gap>0 inserts idle cycles before odd words
    task automatic load_words(input bit kern, input bit both, input int gap);
        int n;
        n = kern ? KK : NN;
        load_kernel = kern | both;
        load_input  = !kern | both;
        tick();
        load_kernel = 1'b0;
        load_input  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && (i % 2) == 1) begin
                data_valid = 1'b0;
                for (int g = 0; g < gap; g++) tick();
            end
            data_in    = kern ? wbuf[i] : pbuf[i];
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for prod_valid; returns number of edges waited
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!prod_valid && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if ({prod_valid, busy, done, pixel_index} !== 5'b0 || multiplied_image !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got valid=%b busy=%b done=%b idx=%0d img=%h want all 0",
                     prod_valid, busy, done, pixel_index, multiplied_image);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_unloaded();
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({busy, prod_valid, done} !== 3'b000) begin
                n_err++;
                $display("FAIL start_unloaded c%0d got busy=%b valid=%b done=%b want 000",
                         c, busy, prod_valid, done);
            end
            tick();
        end
    endtask

    task automatic test_basic_pass();
        int cnt;
        for (int k = 0; k < KK; k++) wbuf[k] = PW'(k + 1);
        pbuf[0] = 8'd2; pbuf[1] = 8'd3; pbuf[2] = 8'd4; pbuf[3] = 8'd5;
        load_words(1'b1, 1'b0, 0);
        load_words(1'b0, 1'b0, 0);
        prod_ready = 1'b1;
        pulse_start();
        n_vec++;
        if (busy !== 1'b1 || prod_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_mult_state got busy=%b valid=%b want 1 0", busy, prod_valid);
        end
        for (int p = 0; p < NN; p++) begin
            wait_valid(cnt);
            n_vec++;
            if (cnt !== 1) begin
                n_err++;
                $display("FAIL basic_spacing vec%0d got %0d want 1", p, cnt);
            end
            n_vec++;
            if (pixel_index !== 2'(p) || multiplied_image !== exp_vec(pbuf[p])) begin
                n_err++;
                $display("FAIL basic_vec%0d got idx=%0d img=%h want idx=%0d img=%h",
                         p, pixel_index, multiplied_image, p, exp_vec(pbuf[p]));
            end
            if (p == 0) begin
                n_vec++;
                if (multiplied_image !== {16'd18, 16'd16, 16'd14, 16'd12, 16'd10,
                                          16'd8, 16'd6, 16'd4, 16'd2}) begin
                    n_err++;
                    $display("FAIL basic_vec0_const got %h", multiplied_image);
                end
            end
            if (p == 3) begin
                n_vec++;
                if (multiplied_image[8*PW2 +: PW2] !== 16'd45) begin
                    n_err++;
                    $display("FAIL basic_vec3_p8 got %0d want 45", multiplied_image[8*PW2 +: PW2]);
                end
            end
            tick();
            n_vec++;
            if (prod_valid !== 1'b0 || done !== (p == NN - 1)) begin
                n_err++;
                $display("FAIL basic_accept%0d got valid=%b done=%b want 0 %b",
                         p, prod_valid, done, p == NN - 1);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        prod_ready = 1'b1;
        pulse_start();
        for (int p = 0; p < NN; p++) begin
            wait_valid(cnt);
            n_vec++;
            if (pixel_index !== 2'(p) || multiplied_image !== exp_vec(pbuf[p])) begin
                n_err++;
                $display("FAIL bp_vec%0d got idx=%0d img=%h want idx=%0d img=%h",
                         p, pixel_index, multiplied_image, p, exp_vec(pbuf[p]));
            end
            if (p == 1) begin
                prod_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    n_vec++;
                    if (prod_valid !== 1'b1 || pixel_index !== 2'd1 ||
                        multiplied_image !== {16'd27, 16'd24, 16'd21, 16'd18, 16'd15,
                                              16'd12, 16'd9, 16'd6, 16'd3}) begin
                        n_err++;
                        $display("FAIL bp_hold s%0d got valid=%b idx=%0d img=%h",
                                 s, prod_valid, pixel_index, multiplied_image);
                    end
                end
                prod_ready = 1'b1;
            end
            tick();
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_full_scale();
        int cnt;
        for (int k = 0; k < KK; k++) wbuf[k] = 8'hFF;
        for (int p = 0; p < NN; p++) pbuf[p] = 8'hFF;
        load_words(1'b1, 1'b0, 0);
        load_words(1'b0, 1'b0, 0);
        prod_ready = 1'b1;
        pulse_start();
        for (int p = 0; p < NN; p++) begin
            wait_valid(cnt);
            n_vec++;
            if (prod_valid !== 1'b1 || multiplied_image !== {9{16'hFE01}}) begin
                n_err++;
                $display("FAIL full_scale vec%0d got valid=%b img=%h want all fe01",
                         p, prod_valid, multiplied_image);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset_mid_pass();
        int cnt;
        for (int k = 0; k < KK; k++) wbuf[k] = PW'(k + 1);
        pbuf[0] = 8'd2; pbuf[1] = 8'd3; pbuf[2] = 8'd4; pbuf[3] = 8'd5;
        load_words(1'b1, 1'b0, 0);
        load_words(1'b0, 1'b0, 0);
        prod_ready = 1'b1;
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            wait_valid(cnt);
            if (p < 2) tick();
        end
        n_vec++;
        if (prod_valid !== 1'b1 || pixel_index !== 2'd2) begin
            n_err++;
            $display("FAIL rst_mid_at_vec2 got valid=%b idx=%0d want 1 2", prod_valid, pixel_index);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({prod_valid, busy, done, pixel_index} !== 5'b0 || multiplied_image !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got valid=%b busy=%b done=%b idx=%0d img=%h want all 0",
                     prod_valid, busy, done, pixel_index, multiplied_image);
        end
        pulse_start();
        tick();
        n_vec++;
        if (busy !== 1'b0 || prod_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_start_none got busy=%b valid=%b want 0 0", busy, prod_valid);
        end
        load_words(1'b1, 1'b0, 0);
        pulse_start();
        tick();
        n_vec++;
        if (busy !== 1'b0 || prod_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_start_konly got busy=%b valid=%b want 0 0", busy, prod_valid);
        end
        load_words(1'b0, 1'b0, 0);
        pulse_start();
        wait_valid(cnt);
        n_vec++;
        if (cnt !== 1 || pixel_index !== 2'd0 || multiplied_image !== exp_vec(pbuf[0])) begin
            n_err++;
            $display("FAIL rst_mid_reload got wait=%0d idx=%0d img=%h want 1 0 %h",
                     cnt, pixel_index, multiplied_image, exp_vec(pbuf[0]));
        end
        for (int p = 0; p < NN; p++) begin
            wait_valid(cnt);
            tick();
        end
        tick();
    endtask

    task automatic test_both_loads();
        int cnt;
        for (int k = 0; k < KK; k++) wbuf[k] = PW'(9 - k);
        load_kernel = 1'b1;
        load_input  = 1'b1;
        tick();
        load_kernel = 1'b0;
        load_input  = 1'b0;
        for (int i = 0; i < KK; i++) begin
            if (i % 2 == 1) begin
                data_valid = 1'b0;
                tick(); tick();
            end
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL both_busy word%0d got %b want 1", i, busy);
            end
            data_in    = wbuf[i];
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL both_back_idle got busy=%b want 0", busy);
        end
        prod_ready = 1'b1;
        pulse_start();
        wait_valid(cnt);
        n_vec++;
        if (cnt !== 1 || multiplied_image !== {16'd2, 16'd4, 16'd6, 16'd8, 16'd10,
                                              16'd12, 16'd14, 16'd16, 16'd18}) begin
            n_err++;
            $display("FAIL both_new_weights got wait=%0d img=%h", cnt, multiplied_image);
        end
        for (int p = 0; p < NN; p++) begin
            wait_valid(cnt);
            tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_start_unloaded();
        test_basic_pass();
        test_backpressure();
        test_full_scale();
        test_reset_mid_pass();
        test_both_loads();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
